// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message-schedule sequencer.
//   SCHED_LOAD_WORDS : message words streamed straight through per block (W0..W15)
//   SCHED_ROUNDS     : schedule words emitted per block (W0..W63)
//   SCHED_EXP_WORDS  : words the schedule unit has to compute per block (W16..W63)
//   sched_ctrl_st_t  : sequencer state
package sha256_pkg;

  localparam int SCHED_LOAD_WORDS = 16;
  localparam int SCHED_ROUNDS     = 64;
  localparam int SCHED_EXP_WORDS  = SCHED_ROUNDS - SCHED_LOAD_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_LOAD,
    ST_EXPAND,
    ST_DRAIN,
    ST_FIN
  } sched_ctrl_st_t;

endpackage

// File: rtl/sha256_msg_sched_ctrl.sv
// Sequencer for an external SHA-256 message-schedule unit.
// Streams num_blocks 512-bit blocks in, as 32-bit words, and emits W[0..63] per
// block on a backpressured output stream. The unit is frozen by withholding
// sched_running, so it only ever shifts on a cycle that moves a word.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   start, num_blocks              job request (ignored while busy)
//   busy, done                     job status, done = one-cycle pulse
//   in_data/in_valid/in_ready      message word input stream
//   w_data/w_valid/w_ready         schedule word output stream
//   w_idx, w_last_blk              round index of w_data, final-block flag
//   sched_run/running/in/delay     controls to the schedule unit
//   sched_out                      registered unit output (changes on running only)
module sha256_msg_sched_ctrl #(
  parameter int BLK_W   = 16,
  parameter int DELAY_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLK_W-1:0]   num_blocks,
  output logic               busy,
  output logic               done,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [31:0]        w_data,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [5:0]         w_idx,
  output logic               w_last_blk,
  output logic               sched_run,
  output logic               sched_running,
  output logic [31:0]        sched_in,
  output logic [DELAY_W-1:0] sched_delay,
  input  logic [31:0]        sched_out
);
  import sha256_pkg::*;

  sched_ctrl_st_t   st;
  logic [BLK_W-1:0] blk_cnt;
  logic [BLK_W-1:0] nblk;
  logic [5:0]       idx;    // index of the word on the output (LOAD) or held in sched_out
  logic [5:0]       fires;  // expansion shifts issued this block
  logic             pend;   // sched_out holds a word the consumer has not taken yet

  logic in_load, in_exp, in_drain;
  logic fire, out_hs, pend_n;

  assign in_load  = (st == ST_LOAD);
  assign in_exp   = (st == ST_EXPAND);
  assign in_drain = (st == ST_DRAIN);

  // sched_out is the only buffer: shift the unit when it is empty or is being
  // emptied this cycle, giving 1 W/cycle under continuous w_ready.
  assign fire   = in_exp && (fires < 6'(SCHED_EXP_WORDS)) && (!pend || w_ready);
  assign out_hs = w_valid && w_ready;
  assign pend_n = fire || (pend && !w_ready);

  // In LOAD the input and output handshakes are one event, so every word that
  // enters the unit is also seen by the consumer.
  assign w_valid       = in_load ? in_valid : ((in_exp || in_drain) && pend);
  assign w_data        = in_load ? in_data : ((in_exp || in_drain) ? sched_out : '0);
  assign in_ready      = in_load && w_ready;
  assign sched_in      = in_load ? in_data : '0;
  assign sched_running = in_load ? (in_valid && w_ready) : fire;
  assign sched_run     = (st == ST_ARM);
  assign sched_delay   = '0;
  assign busy          = (st != ST_IDLE);
  assign done          = (st == ST_FIN);
  assign w_idx         = idx;
  assign w_last_blk    = busy && (blk_cnt == nblk - BLK_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= ST_IDLE;
      blk_cnt <= '0;
      nblk    <= '0;
      idx     <= '0;
      fires   <= '0;
      pend    <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start) begin
            blk_cnt <= '0;
            nblk    <= num_blocks;
            st      <= (num_blocks != '0) ? ST_ARM : ST_FIN;
          end
        end
        // Every block reloads the unit so its load latency restarts cleanly.
        ST_ARM: begin
          idx   <= '0;
          fires <= '0;
          pend  <= 1'b0;
          st    <= ST_LOAD;
        end
        ST_LOAD: begin
          if (in_valid && w_ready) begin
            idx <= idx + 6'd1;
            if (idx == 6'(SCHED_LOAD_WORDS - 1)) st <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          pend <= pend_n;
          if (out_hs) idx <= idx + 6'd1;
          if (fire) begin
            fires <= fires + 6'd1;
            if (fires == 6'(SCHED_EXP_WORDS - 1)) st <= ST_DRAIN;
          end
        end
        // Only W63 remains in sched_out; the block ends when it is taken.
        ST_DRAIN: begin
          pend <= pend_n;
          if (out_hs) begin
            idx     <= idx + 6'd1;
            blk_cnt <= blk_cnt + BLK_W'(1);
            st      <= ((blk_cnt + BLK_W'(1)) < nblk) ? ST_ARM : ST_FIN;
          end
        end
        ST_FIN:  st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched_ctrl.sv
module tb_sha256_msg_sched_ctrl;
  localparam int BLK_W   = 16;
  localparam int DELAY_W = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [BLK_W-1:0]   num_blocks;
  logic               busy, done;
  logic [31:0]        in_data;
  logic               in_valid, in_ready;
  logic [31:0]        w_data;
  logic               w_valid, w_ready;
  logic [5:0]         w_idx;
  logic               w_last_blk;
  logic               sched_run, sched_running;
  logic [31:0]        sched_in;
  logic [DELAY_W-1:0] sched_delay;
  logic [31:0]        sched_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] msg_q[$];
  bit          is_abc;

  always #5 clk = ~clk;

  sha256_msg_sched_ctrl #(.BLK_W(BLK_W), .DELAY_W(DELAY_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
    .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .w_idx(w_idx), .w_last_blk(w_last_blk),
    .sched_run(sched_run), .sched_running(sched_running),
    .sched_in(sched_in), .sched_delay(sched_delay), .sched_out(sched_out)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Stand-in for the external schedule unit: first 16 shifts load in0, later
  // shifts produce the next expanded word; out0 is registered.
  logic [31:0] u_w [0:63];
  int          u_k = 0;
  function automatic logic [31:0] unit_next(input int k);
    return ssig1(u_w[k-2]) + u_w[k-7] + ssig0(u_w[k-15]) + u_w[k-16];
  endfunction
  always @(posedge clk) begin
    if (sched_run) u_k <= 0;
    else if (sched_running && u_k < 64) begin
      if (u_k < 16) begin
        u_w[u_k]  <= sched_in;
        sched_out <= sched_in;
      end else begin
        u_w[u_k]  <= unit_next(u_k);
        sched_out <= unit_next(u_k);
      end
      u_k <= u_k + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_w_valid"}, w_valid, 0);
    chk({tag, "_w_last_blk"}, w_last_blk, 0);
    chk({tag, "_sched_run"}, sched_run, 0);
    chk({tag, "_sched_running"}, sched_running, 0);
    chk({tag, "_w_idx"}, w_idx, 0);
    chk({tag, "_sched_delay"}, sched_delay, 0);
  endtask

  task automatic load_abc();
    msg_q = {};
    msg_q.push_back(32'h61626380);
    for (int i = 1; i < 15; i++) msg_q.push_back(32'h0);
    msg_q.push_back(32'h00000018);
  endtask

  // Two blocks: 56 random message bytes, then padding with bit length 448.
  task automatic load_448();
    msg_q = {};
    for (int i = 0; i < 14; i++) msg_q.push_back($urandom);
    msg_q.push_back(32'h80000000);
    msg_q.push_back(32'h0);
    for (int i = 0; i < 15; i++) msg_q.push_back(32'h0);
    msg_q.push_back(32'h000001c0);
  endtask

  task automatic load_rand(input int nb);
    msg_q = {};
    for (int i = 0; i < 16 * nb; i++) msg_q.push_back($urandom);
  endtask

  task automatic run_job(input int nb, input bit rnd, input int abort_idx, input bit poke);
    logic [31:0] ew[$];
    logic [31:0] w [0:63];
    int wp, blk, eidx, ndone, nrun, nrunp, nw, last_hs, done_cyc, budget;
    bit fin, aborted, rdy_seen;
    ew = {};
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 16; i++) w[i] = msg_q[16*b + i];
      for (int i = 16; i < 64; i++) w[i] = ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16];
      for (int i = 0; i < 64; i++) ew.push_back(w[i]);
    end
    wp = 0; blk = 0; eidx = 0; ndone = 0; nrun = 0; nrunp = 0; nw = 0;
    last_hs = -1; done_cyc = -1; fin = 0; aborted = 0; rdy_seen = 0;
    budget = 2000 * nb + 20;
    for (int cyc = 0; cyc < budget && !fin && !aborted; cyc++) begin
      @(negedge clk);
      start      = (cyc == 0) || (poke && cyc == 40);
      num_blocks = (cyc == 0) ? 16'(nb) : 16'(nb + 3);
      w_ready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wp < 16 * nb) begin
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = msg_q[wp];
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end
      #1;
      if (cyc == 0) chk("idle_before_start", busy, 0);
      if (in_ready) rdy_seen = 1;
      if (in_valid && in_ready) wp++;
      if (sched_running) nrun++;
      if (sched_run) nrunp++;
      if (done) begin ndone++; done_cyc = cyc; fin = 1; end
      if (w_valid && w_ready) begin
        if (abort_idx >= 0 && eidx == abort_idx) begin
          rst = 1'b1;
          #1;
          check_quiet("abort");
          aborted = 1;
        end else begin
          chk("w_idx", w_idx, eidx);
          if (64*blk + eidx < ew.size()) chk("w_data", w_data, ew[64*blk + eidx]);
          else chk("extra_word", 1, 0);
          chk("w_last_blk", w_last_blk, (blk == nb - 1));
          if (is_abc && eidx == 16) chk("abc_w16", w_data, 32'h61626380);
          if (is_abc && eidx == 63) chk("abc_w63", w_data, 32'h12b1edeb);
          nw++; last_hs = cyc; eidx++;
          if (eidx == 64) begin eidx = 0; blk++; end
        end
      end
    end
    start = 1'b0; in_valid = 1'b0; w_ready = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    chk("done_seen", fin, 1);
    repeat (4) begin
      @(negedge clk);
      #1;
      if (done) ndone++;
    end
    chk("done_count", ndone, 1);
    chk("run_pulses", nrunp, nb);
    chk("running_count", nrun, 64 * nb);
    chk("word_count", nw, 64 * nb);
    chk("msg_consumed", wp, 16 * nb);
    if (nb > 0) chk("done_latency", done_cyc, last_hs + 1);
    else begin
      chk("done_early", (done_cyc >= 1 && done_cyc <= 2), 1);
      chk("in_ready_zero", rdy_seen, 0);
    end
    chk("idle_after", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_blocks = '0;
    in_data = '0; in_valid = 1'b0; w_ready = 1'b0; is_abc = 0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;

    load_abc(); is_abc = 1;
    run_job(1, 0, -1, 0);
    run_job(1, 1, -1, 0);

    load_448(); is_abc = 0;
    run_job(2, 1, -1, 0);

    msg_q = {};
    run_job(0, 0, -1, 0);

    load_abc(); is_abc = 1;
    run_job(1, 0, 30, 0);
    run_job(1, 1, -1, 0);

    load_rand(2); is_abc = 0;
    run_job(2, 1, -1, 1);

    load_rand(3);
    run_job(3, 1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
